// File: rtl/case_4_sdiv_10s_7s_10_seq.sv
// Multi-cycle signed divider: 10-bit signed dividend / 7-bit signed divisor.
// Radix-2 restoring iteration on operand magnitudes, C-style truncation
// toward zero. Remainder takes the sign of the dividend.
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   in_valid / in_ready     operand handshake (din0 dividend, din1 divisor)
//   out_valid / out_ready   result handshake (quot, rem, div_by_zero, overflow)
module case_4_sdiv_10s_7s_10_seq #(
    parameter int unsigned din0_WIDTH = 10,
    parameter int unsigned din1_WIDTH = 7,
    parameter int unsigned dout_WIDTH = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(din0_WIDTH);
    localparam int unsigned PR_W  = din1_WIDTH + 1;

    localparam logic [din0_WIDTH-1:0] DIN0_MIN = {1'b1, {(din0_WIDTH-1){1'b0}}};
    localparam logic [din1_WIDTH-1:0] DIN1_M1  = {din1_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(din0_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q;
    logic [din0_WIDTH-1:0] dvd_q;      // dividend magnitude, shifted out MSB first
    logic [din1_WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [PR_W-1:0]       pr_q;       // partial remainder
    logic [din0_WIDTH-1:0] quo_q;      // unsigned quotient being built
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_q_q;
    logic                  sign_r_q;
    logic                  zero_q;
    logic                  ovf_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [dout_WIDTH-1:0] quot_q;
    logic [din1_WIDTH-1:0] rem_q;
    logic                  dbz_q;
    logic                  ovf_out_q;

    logic [din0_WIDTH-1:0] din0_abs_c;
    logic [din1_WIDTH-1:0] din1_abs_c;
    logic [PR_W-1:0]       shift_c;
    logic [PR_W:0]         trial_c;

    // Operand magnitudes; the most-negative dividend maps to its unsigned magnitude.
    always_comb begin
        din0_abs_c = din0[din0_WIDTH-1] ? -din0 : din0;
        din1_abs_c = din1[din1_WIDTH-1] ? -din1 : din1;
    end

    // One restoring step: bring in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shift_c = {pr_q[din1_WIDTH-1:0], dvd_q[din0_WIDTH-1]};
        trial_c = {1'b0, shift_c} - {2'b00, dvs_q};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dvd_q      <= din0_abs_c;
                        dvs_q      <= din1_abs_c;
                        sign_q_q   <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        sign_r_q   <= din0[din0_WIDTH-1];
                        zero_q     <= (din1 == '0);
                        ovf_q      <= (din0 == DIN0_MIN) && (din1 == DIN1_M1);
                        pr_q       <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    dvd_q <= {dvd_q[din0_WIDTH-2:0], 1'b0};
                    if (!trial_c[PR_W]) begin
                        pr_q  <= trial_c[PR_W-1:0];
                        quo_q <= {quo_q[din0_WIDTH-2:0], 1'b1};
                    end else begin
                        pr_q  <= shift_c;
                        quo_q <= {quo_q[din0_WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Overflow needs no special quotient: magnitude 2^(W-1) wraps to the minimum.
                    if (zero_q) begin
                        quot_q <= '1;
                        rem_q  <= '0;
                    end else if (ovf_q) begin
                        quot_q <= dout_WIDTH'(quo_q);
                        rem_q  <= '0;
                    end else begin
                        quot_q <= dout_WIDTH'(sign_q_q ? -quo_q : quo_q);
                        rem_q  <= sign_r_q ? -pr_q[din1_WIDTH-1:0] : pr_q[din1_WIDTH-1:0];
                    end
                    dbz_q       <= zero_q;
                    ovf_out_q   <= ovf_q && !zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_case_4_sdiv_10s_7s_10_seq.sv
// Directed testbench for case_4_sdiv_10s_7s_10_seq.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_case_4_sdiv_10s_7s_10_seq;

    localparam int LAT = 12;   // cycle index of first out_valid, accept cycle = 0
    localparam int GAP = 13;   // accept-to-accept spacing with out_ready held high

    logic              ap_clk;
    logic              ap_rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [9:0] din0;
    logic signed [6:0] din1;
    logic              out_valid;
    logic              out_ready;
    logic signed [9:0] quot;
    logic signed [6:0] rem;
    logic              div_by_zero;
    logic              overflow;

    int n_cmp = 0;
    int n_bad = 0;

    case_4_sdiv_10s_7s_10_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Issue one division and return the cycle index at which out_valid is first seen (-1 on timeout).
    task automatic run_div(input logic signed [9:0] a, input logic signed [6:0] b, output int lat);
        int w;
        w = 0;
        @(negedge ap_clk);
        while (!in_ready && w < 30) begin
            @(negedge ap_clk);
            w++;
        end
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        @(posedge ap_clk);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge ap_clk);
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Accept the pending result for one edge.
    task automatic finish_xfer();
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        #2 ap_rst = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (quot !== 10'sd0) begin n_bad++; $display("FAIL reset_quot got=%0d exp=0", quot); end
        n_cmp++;
        if (rem !== 7'sd0) begin n_bad++; $display("FAIL reset_rem got=%0d exp=0", rem); end
        n_cmp++;
        if ({div_by_zero, overflow} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags got=%b%b exp=00", div_by_zero, overflow);
        end
        n_cmp++;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        n_cmp++;
    endtask

    task automatic test_basic();
        int lat;
        run_div(10'sd100, 7'sd7, lat);
        if (lat !== LAT) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++;
        if (quot !== 10'sd14) begin n_bad++; $display("FAIL basic_quot got=%0d exp=14", quot); end
        n_cmp++;
        if (rem !== 7'sd2) begin n_bad++; $display("FAIL basic_rem got=%0d exp=2", rem); end
        n_cmp++;
        if ({div_by_zero, overflow} !== 2'b00) begin
            n_bad++; $display("FAIL basic_flags got=%b%b exp=00", div_by_zero, overflow);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_ready got=%b exp=0", in_ready); end
        n_cmp++;
        finish_xfer();
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
        n_cmp++;
    endtask

    task automatic test_signs();
        logic signed [9:0] va [3];
        logic signed [6:0] vb [3];
        logic signed [9:0] eq [3];
        logic signed [6:0] er [3];
        int lat;
        va[0] = -10'sd100; vb[0] =  7'sd7; eq[0] = -10'sd14; er[0] = -7'sd2;
        va[1] =  10'sd100; vb[1] = -7'sd7; eq[1] = -10'sd14; er[1] =  7'sd2;
        va[2] = -10'sd100; vb[2] = -7'sd7; eq[2] =  10'sd14; er[2] = -7'sd2;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat);
            if (quot !== eq[i]) begin n_bad++; $display("FAIL signs_quot[%0d] got=%0d exp=%0d", i, quot, eq[i]); end
            n_cmp++;
            if (rem !== er[i]) begin n_bad++; $display("FAIL signs_rem[%0d] got=%0d exp=%0d", i, rem, er[i]); end
            n_cmp++;
            if ({div_by_zero, overflow} !== 2'b00) begin
                n_bad++; $display("FAIL signs_flags[%0d] got=%b%b exp=00", i, div_by_zero, overflow);
            end
            n_cmp++;
            finish_xfer();
        end
    endtask

    task automatic test_extremes();
        logic signed [9:0] va [3];
        logic signed [6:0] vb [3];
        logic signed [9:0] eq [3];
        logic signed [6:0] er [3];
        logic              eo [3];
        int lat;
        va[0] = -10'sd512; vb[0] = -7'sd1;  eq[0] = -10'sd512; er[0] = 7'sd0;  eo[0] = 1'b1;
        va[1] = -10'sd512; vb[1] =  7'sd1;  eq[1] = -10'sd512; er[1] = 7'sd0;  eo[1] = 1'b0;
        va[2] =  10'sd511; vb[2] = -7'sd64; eq[2] = -10'sd7;   er[2] = 7'sd63; eo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat);
            if (lat !== LAT) begin n_bad++; $display("FAIL ext_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
            n_cmp++;
            if (quot !== eq[i]) begin n_bad++; $display("FAIL ext_quot[%0d] got=%0d exp=%0d", i, quot, eq[i]); end
            n_cmp++;
            if (rem !== er[i]) begin n_bad++; $display("FAIL ext_rem[%0d] got=%0d exp=%0d", i, rem, er[i]); end
            n_cmp++;
            if ({div_by_zero, overflow} !== {1'b0, eo[i]}) begin
                n_bad++; $display("FAIL ext_flags[%0d] got=%b%b exp=0%b", i, div_by_zero, overflow, eo[i]);
            end
            n_cmp++;
            finish_xfer();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_div(10'sd37, 7'sd0, lat);
        if (lat !== LAT) begin n_bad++; $display("FAIL dz_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++;
        if (quot !== 10'h3FF) begin n_bad++; $display("FAIL dz_quot got=%h exp=3ff", quot); end
        n_cmp++;
        if (rem !== 7'sd0) begin n_bad++; $display("FAIL dz_rem got=%0d exp=0", rem); end
        n_cmp++;
        if ({div_by_zero, overflow} !== 2'b10) begin
            n_bad++; $display("FAIL dz_flags got=%b%b exp=10", div_by_zero, overflow);
        end
        n_cmp++;
        finish_xfer();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [20:0] exp_v;
        logic [20:0] got_v;
        logic        seen;
        run_div(10'sd50, 7'sd3, lat);
        if (lat !== LAT) begin n_bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++;
        // out_valid, in_ready, quot=16, rem=2, no flags
        exp_v = {1'b1, 1'b0, 10'sd16, 7'sd2, 1'b0, 1'b0};
        for (int i = 0; i < 20; i++) begin
            got_v = {out_valid, in_ready, quot, rem, div_by_zero, overflow};
            if (got_v !== exp_v) begin
                n_bad++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, got_v, exp_v);
            end
            n_cmp++;
            @(negedge ap_clk);
            if (i == 5) begin
                din0     = 10'sd9;
                din1     = 7'sd2;
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
        end
        finish_xfer();
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge ap_clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_ignored_input got=%b exp=0", seen); end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int w;
        logic seen;
        w = 0;
        @(negedge ap_clk);
        while (!in_ready && w < 30) begin
            @(negedge ap_clk);
            w++;
        end
        din0     = 10'sd100;
        din1     = 7'sd7;
        in_valid = 1'b1;
        @(posedge ap_clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge ap_clk);
            if (c == 1) in_valid = 1'b0;
        end
        ap_rst = 1'b1;
        #1;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++; $display("FAIL rstmid_handshake got=%b%b exp=10", in_ready, out_valid);
        end
        n_cmp++;
        if (quot !== 10'sd0) begin n_bad++; $display("FAIL rstmid_quot got=%0d exp=0", quot); end
        n_cmp++;
        if ({rem, div_by_zero, overflow} !== 9'd0) begin
            n_bad++; $display("FAIL rstmid_rem_flags got=%0d %b%b exp=0 00", rem, div_by_zero, overflow);
        end
        n_cmp++;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge ap_clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_result got=%b exp=0", seen); end
        n_cmp++;
        run_div(10'sd100, 7'sd7, lat);
        if (lat !== LAT) begin n_bad++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++;
        if ({quot, rem} !== {10'sd14, 7'sd2}) begin
            n_bad++; $display("FAIL rstmid_result got=%0d r %0d exp=14 r 2", quot, rem);
        end
        n_cmp++;
        finish_xfer();
    endtask

    task automatic test_back_to_back();
        int acc [2];
        logic signed [9:0] rq [2];
        logic signed [6:0] rr [2];
        int nacc;
        int nres;
        nacc = 0;
        nres = 0;
        acc[0] = 0; acc[1] = 0;
        rq[0] = '0; rq[1] = '0;
        rr[0] = '0; rr[1] = '0;
        @(negedge ap_clk);
        din0      = 10'sd100;
        din1      = 7'sd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (nacc == 1 && c == acc[0] + 1) din0 = -10'sd100;
            if (nacc == 2 && c == acc[1] + 1) in_valid = 1'b0;
            if (out_valid && nres < 2) begin
                rq[nres] = quot;
                rr[nres] = rem;
                nres++;
            end
            if (in_ready && in_valid && nacc < 2) begin
                acc[nacc] = c;
                nacc++;
            end
            @(negedge ap_clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if ({nacc, nres} !== {32'sd2, 32'sd2}) begin
            n_bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", nacc, nres);
        end
        n_cmp++;
        if (acc[1] - acc[0] !== GAP) begin
            n_bad++; $display("FAIL b2b_gap got=%0d exp=%0d", acc[1] - acc[0], GAP);
        end
        n_cmp++;
        if ({rq[0], rr[0]} !== {10'sd14, 7'sd2}) begin
            n_bad++; $display("FAIL b2b_first got=%0d r %0d exp=14 r 2", rq[0], rr[0]);
        end
        n_cmp++;
        if ({rq[1], rr[1]} !== {-10'sd14, -7'sd2}) begin
            n_bad++; $display("FAIL b2b_second got=%0d r %0d exp=-14 r -2", rq[1], rr[1]);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
